// File: rtl/rbm_image_feeder_pkg.sv
// Shared types and default sizes for the RBM image feeder.
// FSM state encoding plus the default pixel/score geometry.
package rbm_image_feeder_pkg;

  localparam int BITLENGTH  = 12;
  localparam int INPUT_DIM  = 784;
  localparam int OUTPUT_DIM = 10;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_ARGMAX  = 2'd2,
    ST_PRESENT = 2'd3
  } fsm_e;

  function automatic logic rise(
    input logic cur,
    input logic prev
  );
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/rbm_argmax_seq.sv
// Sequential signed argmax: one score per cycle, strict '>', ties keep lowest.
// Ports: clock, reset (async low), start_i, scores_i (packed) -> done_o, index_o.
module rbm_argmax_seq #(
  parameter int W = 12,
  parameter int N = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [N*W-1:0]       scores_i,
  output logic                 done_o,
  output logic [$clog2(N)-1:0] index_o
);

  localparam int IW = $clog2(N);

  logic                 busy_q;
  logic [IW-1:0]        cnt_q;
  logic [IW-1:0]        best_idx_q;
  logic signed [W-1:0]  best_val_q;
  logic signed [W-1:0]  cur;
  logic                 take;
  logic                 last;

  assign cur  = scores_i[cnt_q*W +: W];
  // First score is always taken so no sentinel minimum is needed.
  assign take = (cnt_q == '0) || (cur > best_val_q);
  assign last = (cnt_q == IW'(N-1));

  // index_o is the final answer during the done cycle.
  assign done_o  = busy_q & last;
  assign index_o = take ? cnt_q : best_idx_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      best_idx_q <= index_o;
      best_val_q <= take ? cur : best_val_q;
      if (last) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rbm_image_feeder.sv
// Loads a serial image for Main, captures its scores on finish, argmaxes them
// and presents label+scores over valid/ready. Pixel in, image/data_valid out.
module rbm_image_feeder
  import rbm_image_feeder_pkg::*;
#(
  parameter int bitlength  = BITLENGTH,
  parameter int input_dim  = INPUT_DIM,
  parameter int output_dim = OUTPUT_DIM
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            pix_valid,
  input  logic [bitlength-1:0]            pix_data,
  input  logic                            pix_last,
  output logic                            pix_ready,
  output logic [input_dim*bitlength-1:0]  InputDataPort,
  output logic                            data_valid,
  input  logic                            finish,
  input  logic [output_dim*bitlength-1:0] OutputDataPort,
  output logic                            result_valid,
  input  logic                            result_ready,
  output logic [$clog2(output_dim)-1:0]   result_label,
  output logic [output_dim*bitlength-1:0] result_scores
);

  localparam int IDXW = $clog2(input_dim) + 1;
  localparam int LW   = $clog2(output_dim);

  fsm_e state_q, state_d;

  logic [IDXW-1:0]                 idx_q;
  logic [input_dim*bitlength-1:0]  img_q;
  logic [output_dim*bitlength-1:0] scores_q;
  logic [LW-1:0]                   label_q;
  logic                            finish_d_q;

  logic                 beat;
  logic                 at_end;
  logic                 fin_rise;
  logic                 hs;
  logic                 am_start;
  logic                 am_done;
  logic [LW-1:0]        am_index;
  logic [input_dim-1:0] we;

  assign beat     = pix_valid & pix_ready;
  assign at_end   = beat & (pix_last | (idx_q == IDXW'(input_dim-1)));
  assign fin_rise = rise(finish, finish_d_q);
  assign hs       = result_valid & result_ready;
  assign am_start = (state_q == ST_RUN) & fin_rise;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOAD:    if (at_end)   state_d = ST_RUN;
      ST_RUN:     if (fin_rise) state_d = ST_ARGMAX;
      ST_ARGMAX:  if (am_done)  state_d = ST_PRESENT;
      ST_PRESENT: if (hs)       state_d = ST_LOAD;
      default:                  state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    pix_ready    = 1'b0;
    data_valid   = 1'b0;
    result_valid = 1'b0;
    unique case (state_q)
      ST_LOAD:    pix_ready    = 1'b1;
      ST_RUN:     data_valid   = 1'b1;
      ST_PRESENT: result_valid = 1'b1;
      default:    ;
    endcase
  end

  always_comb begin
    for (int i = 0; i < input_dim; i++) begin
      we[i] = beat && (idx_q == IDXW'(i));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
      img_q <= '0;
    end else if (hs) begin
      idx_q <= '0;
      img_q <= '0;
    end else begin
      if (beat) idx_q <= idx_q + 1'b1;
      for (int i = 0; i < input_dim; i++) begin
        if (we[i]) img_q[i*bitlength +: bitlength] <= pix_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      finish_d_q <= 1'b0;
      scores_q   <= '0;
      label_q    <= '0;
    end else begin
      finish_d_q <= finish;
      if (am_start) scores_q <= OutputDataPort;
      if (am_done)  label_q  <= am_index;
    end
  end

  rbm_argmax_seq #(
    .W (bitlength),
    .N (output_dim)
  ) u_argmax (
    .clock    (clock),
    .reset    (reset),
    .start_i  (am_start),
    .scores_i (scores_q),
    .done_o   (am_done),
    .index_o  (am_index)
  );

  assign InputDataPort = img_q;
  assign result_label  = label_q;
  assign result_scores = scores_q;

endmodule

// File: tb/tb_rbm_image_feeder.sv
// Directed bench for rbm_image_feeder: load, run, argmax, present, reset.
// Drives and samples on the falling edge.
module tb_rbm_image_feeder;

  localparam int W  = 12;
  localparam int ID = 784;
  localparam int OD = 10;

  logic              clock;
  logic              reset;
  logic              pix_valid;
  logic [W-1:0]      pix_data;
  logic              pix_last;
  logic              pix_ready;
  logic [ID*W-1:0]   InputDataPort;
  logic              data_valid;
  logic              finish;
  logic [OD*W-1:0]   OutputDataPort;
  logic              result_valid;
  logic              result_ready;
  logic [3:0]        result_label;
  logic [OD*W-1:0]   result_scores;

  int checks;
  int failures;

  rbm_image_feeder dut (
    .clock          (clock),
    .reset          (reset),
    .pix_valid      (pix_valid),
    .pix_data       (pix_data),
    .pix_last       (pix_last),
    .pix_ready      (pix_ready),
    .InputDataPort  (InputDataPort),
    .data_valid     (data_valid),
    .finish         (finish),
    .OutputDataPort (OutputDataPort),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .result_label   (result_label),
    .result_scores  (result_scores)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic send_beats(input int first, input int n, input bit ramp,
                            input logic [W-1:0] val, input bit last_on_final);
    for (int b = first; b < first + n; b++) begin
      pix_valid = 1'b1;
      pix_data  = ramp ? W'(b % 4096) : val;
      pix_last  = last_on_final && (b == first + n - 1);
      @(negedge clock);
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (pix_ready !== 1'b1 || data_valid !== 1'b0 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got rdy=%b dv=%b rv=%b want 1 0 0",
               pix_ready, data_valid, result_valid);
    end
    checks++;
    if (InputDataPort !== '0 || result_scores !== '0 || result_label !== 4'd0) begin
      failures++;
      $display("FAIL reset_data: got label=%0d want 0, image/scores nonzero", result_label);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_full_image;
    int errs;
    send_beats(0, 783, 1'b1, '0, 1'b0);
    checks++;
    if (data_valid !== 1'b0 || pix_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_pre_last: got dv=%b rdy=%b want 0 1", data_valid, pix_ready);
    end
    send_beats(783, 1, 1'b1, '0, 1'b1);
    checks++;
    if (data_valid !== 1'b1 || pix_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_dv: got dv=%b rdy=%b want 1 0", data_valid, pix_ready);
    end
    pix_valid = 1'b1;
    pix_data  = 12'hABC;
    repeat (3) @(negedge clock);
    pix_valid = 1'b0;
    errs = 0;
    for (int i = 0; i < ID; i++) begin
      if (InputDataPort[i*W +: W] !== W'(i % 4096)) errs++;
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL full_image: got %0d bad elements want 0", errs);
    end
  endtask

  task automatic test_argmax_tie;
    logic [OD*W-1:0] sc;
    int lat;
    sc = '0;
    sc[0*W +: W] = 12'h003;
    sc[1*W +: W] = 12'hFF9;
    sc[2*W +: W] = 12'h7FF;
    sc[3*W +: W] = 12'h7FF;
    OutputDataPort = sc;
    finish = 1'b1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (k == 1) begin
        checks++;
        if (data_valid !== 1'b0) begin
          failures++;
          $display("FAIL tie_dv_drop: got dv=%b want 0", data_valid);
        end
        OutputDataPort = '0;
      end
      if (result_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 11) begin
      failures++;
      $display("FAIL tie_latency: got %0d want 11", lat);
    end
    checks++;
    if (result_label !== 4'd2 || result_scores !== sc) begin
      failures++;
      $display("FAIL tie_label: got %0d want 2 (scores %h want %h)",
               result_label, result_scores, sc);
    end
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
    checks++;
    if (pix_ready !== 1'b1 || result_valid !== 1'b0 || InputDataPort !== '0) begin
      failures++;
      $display("FAIL tie_handshake: got rdy=%b rv=%b want 1 0, buffer cleared",
               pix_ready, result_valid);
    end
  endtask

  task automatic test_early_last;
    int errs;
    send_beats(0, 10, 1'b0, 12'h005, 1'b1);
    errs = 0;
    for (int i = 0; i < ID; i++) begin
      if (InputDataPort[i*W +: W] !== ((i < 10) ? 12'h005 : 12'h000)) errs++;
    end
    checks++;
    if (errs != 0 || data_valid !== 1'b1) begin
      failures++;
      $display("FAIL early_last: got %0d bad elements dv=%b want 0 1", errs, data_valid);
    end
    repeat (5) @(negedge clock);
    checks++;
    if (data_valid !== 1'b1 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL stale_finish: got dv=%b rv=%b want 1 0", data_valid, result_valid);
    end
    finish = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_negative_backpressure;
    logic [OD*W-1:0] sc;
    int lat;
    int bad;
    for (int i = 0; i < OD; i++) sc[i*W +: W] = 12'hF00;
    sc[9*W +: W] = 12'hFFF;
    OutputDataPort = sc;
    finish = 1'b1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (result_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 11 || result_label !== 4'd9) begin
      failures++;
      $display("FAIL neg_label: got label=%0d lat=%0d want 9 11", result_label, lat);
    end
    checks++;
    if (result_scores !== sc) begin
      failures++;
      $display("FAIL neg_scores: got %h want %h", result_scores, sc);
    end
    OutputDataPort = '0;
    pix_valid = 1'b1;
    pix_data  = 12'h123;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (result_valid !== 1'b1 || result_label !== 4'd9 ||
          result_scores !== sc || pix_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL backpressure: got %0d unstable cycles want 0", bad);
    end
    pix_valid    = 1'b0;
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
    checks++;
    if (pix_ready !== 1'b1 || result_valid !== 1'b0 || InputDataPort !== '0) begin
      failures++;
      $display("FAIL bp_release: got rdy=%b rv=%b want 1 0, buffer cleared",
               pix_ready, result_valid);
    end
    finish = 1'b0;
  endtask

  task automatic test_async_reset;
    send_beats(0, 300, 1'b1, '0, 1'b0);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (InputDataPort !== '0 || data_valid !== 1'b0 || pix_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_load: got dv=%b rdy=%b want 0 1, image cleared",
               data_valid, pix_ready);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    send_beats(0, 3, 1'b0, 12'h007, 1'b1);
    checks++;
    if (InputDataPort[0 +: W] !== 12'h007 || InputDataPort[2*W +: W] !== 12'h007 ||
        InputDataPort[3*W +: W] !== 12'h000 || InputDataPort[299*W +: W] !== 12'h000 ||
        data_valid !== 1'b1) begin
      failures++;
      $display("FAIL reload_after_reset: got e0=%h e2=%h e3=%h dv=%b want 007 007 000 1",
               InputDataPort[0 +: W], InputDataPort[2*W +: W],
               InputDataPort[3*W +: W], data_valid);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (data_valid !== 1'b0 || InputDataPort !== '0 || result_scores !== '0 ||
        result_valid !== 1'b0 || result_label !== 4'd0) begin
      failures++;
      $display("FAIL reset_mid_run: got dv=%b rv=%b label=%0d want 0 0 0, data cleared",
               data_valid, result_valid, result_label);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    send_beats(0, 2, 1'b0, 12'h0A5, 1'b1);
    checks++;
    if (InputDataPort[0 +: W] !== 12'h0A5 || InputDataPort[2*W +: W] !== 12'h000 ||
        data_valid !== 1'b1) begin
      failures++;
      $display("FAIL load_after_run_reset: got e0=%h e2=%h dv=%b want 0a5 000 1",
               InputDataPort[0 +: W], InputDataPort[2*W +: W], data_valid);
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    reset          = 1'b0;
    pix_valid      = 1'b0;
    pix_data       = '0;
    pix_last       = 1'b0;
    finish         = 1'b0;
    OutputDataPort = '0;
    result_ready   = 1'b0;
    @(negedge clock);
    test_reset;
    test_full_image;
    test_argmax_tie;
    test_early_last;
    test_negative_backpressure;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
